uart_tx: RTL

UART transmitter that drains the byte FIFO. It sits directly downstream of the FIFO's pop side. Whenever the FIFO is non-empty, it reads the byte at the head, pops it and serialises it onto `tx` as one frame: 8N1, LSB first. Back-to-back frames go out with no idle gap while the FIFO holds data.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_tx_if.sv | 22 ++
 rtl/baud_tick_gen.sv | 37 +++
 rtl/uart_tx.sv | 131 +++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART transmitter.
// State encoding, frame shape and line idle level.
package uart_pkg;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = S_IDLE,
    START = S_START,
    DATA  = S_DATA,
    STOP  = S_STOP
  } state_e;

  localparam int   DATA_BITS = 8;
  localparam int   STOP_BITS = 1;
  localparam logic LINE_IDLE = 1'b1;

  function automatic int calc_div(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// uart_tx_if: FIFO pop-side bundle between byte FIFO and transmitter.
// master = FIFO side, slave = transmitter side.
interface uart_tx_if;
  import uart_pkg::*;

  logic                 fifo_empty;
  logic [DATA_BITS-1:0] fifo_pop_data;
  logic                 fifo_pop;

  modport master (
    output fifo_empty,
    output fifo_pop_data,
    input  fifo_pop
  );

  modport slave (
    input  fifo_empty,
    input  fifo_pop_data,
    output fifo_pop
  );

endinterface

// File: rtl/baud_tick_gen.sv
// baud_tick_gen: free-running 0..DIV-1 divider with sync clear.
// bit_tick marks the last clock of every bit period.
module baud_tick_gen #(
  parameter int DIV = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic bit_tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // next count: wrap at DIV-1, restart on clear
  always_comb begin
    cnt_d = cnt_q + W'(1);
    if (clr || (cnt_q == LAST)) begin
      cnt_d = '0;
    end
  end

  // divider register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bit_tick = (cnt_q == LAST);

endmodule

// File: rtl/uart_tx.sv
// uart_tx: 8N1 LSB-first transmitter draining a byte FIFO.
// Pops at IDLE or on the last stop clock, so frames run gap-free.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_HZ = 100_000_000,
  parameter int BAUD   = 9600
) (
  input  logic      clk,
  input  logic      rst,
  uart_tx_if.slave  fifo,
  output logic      tx,
  output logic      tx_busy,
  output logic      tx_done
);

  localparam int DIV = calc_div(CLK_HZ, BAUD);
  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  generate
    if (DIV < 2) begin : g_div_chk
      $error("uart_tx: CLK_HZ/BAUD must be at least 2");
    end
    if (STOP_BITS != 1) begin : g_stop_chk
      $error("uart_tx: only one stop bit is supported");
    end
  endgenerate

  state_e               state_q;
  state_e               state_d;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] shift_d;
  logic [2:0]           bit_cnt_q;
  logic [2:0]           bit_cnt_d;
  logic                 tx_q;
  logic                 tx_d;
  logic                 bit_tick;
  logic                 load;
  logic                 clr;

  // divider restarts on every load so each bit is exactly DIV clocks
  assign clr = (state_q == IDLE) || load;

  baud_tick_gen #(
    .DIV (DIV)
  ) u_tick (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .bit_tick (bit_tick)
  );

  // next state, load decision and next line level
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    load      = 1'b0;
    tx_done   = 1'b0;
    tx_d      = LINE_IDLE;

    unique case (state_q)
      IDLE: begin
        load = !fifo.fifo_empty;
      end
      START: begin
        if (bit_tick) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (bit_tick) begin
          shift_d   = shift_q >> 1;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == LAST_BIT) begin
            state_d = STOP;
          end
        end
      end
      STOP: begin
        if (bit_tick) begin
          tx_done = 1'b1;
          load    = !fifo.fifo_empty;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // reset beats any pending load or done pulse
    if (rst) begin
      load    = 1'b0;
      tx_done = 1'b0;
    end

    if (load) begin
      state_d   = START;
      shift_d   = fifo.fifo_pop_data;
      bit_cnt_d = '0;
    end

    // line level follows the state being entered, then registered
    unique case (1'b1)
      (state_d == START): tx_d = 1'b0;
      (state_d == DATA):  tx_d = shift_d[0];
      default:            tx_d = LINE_IDLE;
    endcase
  end

  // FSM, shifter, bit counter and line register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      tx_q      <= LINE_IDLE;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      tx_q      <= tx_d;
    end
  end

  assign fifo.fifo_pop = load;
  assign tx            = tx_q;
  assign tx_busy       = (state_q != IDLE);

endmodule
